memory_stage_mc: RTL and testbench

- Parametrised successor to the single-cycle data-memory stage.
- Performs sub-word loads and stores (byte/half/word, signed/unsigned) with byte-lane enables.
- Read latency is configurable; loads longer than one cycle stall upstream.
- Registers all results into the M->W pipeline register; sits between execute/M and writeback.

---
 rtl/memory_stage_mc_pkg.sv | 37 +++
 rtl/memory_stage_mc_if.sv | 44 ++++
 rtl/memory_stage_mc_align.sv | 56 +++++
 rtl/memory_stage_mc.sv | 148 ++++++++++++++
 tb/tb_memory_stage_mc.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_mc_pkg.sv
// rtl/memory_stage_mc_pkg.sv - shared types and constants for the memory stage (package mem_pkg)
package mem_pkg;

  localparam int MEM_WORD     = 32;
  localparam int MEM_REG_SIZE = 5;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Control half of the M->W pipeline register; data fields stay width-parametrised in the stage
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem2reg;
    logic mem_write;
    logic finish;
    logic misalign;
  } w_ctrl_t;

  // The 2'b11 encoding is an alias for a full-word access
  function automatic mem_size_t decode_size(input logic [1:0] s);
    case (s)
      2'b00:   return MEM_B;
      2'b01:   return MEM_H;
      default: return MEM_W;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_mc_if.sv
// rtl/memory_stage_mc_if.sv - M-side inputs and W-side outputs of the memory stage
interface memory_stage_mc_if #(
  parameter int WORD_W   = 32,
  parameter int REG_SIZE = 5
);
  logic                en;
  logic                validM;
  logic [WORD_W-1:0]   pcM;
  logic [WORD_W-1:0]   ALUResultM;
  logic [WORD_W-1:0]   writeDataM;
  logic [REG_SIZE-1:0] writeRegM;
  logic                regWriteM;
  logic                memWriteM;
  logic                mem2regM;
  logic                finishM;
  logic [1:0]          memSizeM;
  logic                memUnsignedM;
  logic                stallM;
  logic [WORD_W-1:0]   readDataW;
  logic [WORD_W-1:0]   ALUResultW;
  logic [WORD_W-1:0]   pcW;
  logic [WORD_W-1:0]   writeDataW;
  logic [REG_SIZE-1:0] writeRegW;
  logic                regWriteW;
  logic                mem2regW;
  logic                memWriteW;
  logic                finishW;
  logic                validW;
  logic                misalignW;

  modport master (
    output en, validM, pcM, ALUResultM, writeDataM, writeRegM,
           regWriteM, memWriteM, mem2regM, finishM, memSizeM, memUnsignedM,
    input  stallM, readDataW, ALUResultW, pcW, writeDataW, writeRegW,
           regWriteW, mem2regW, memWriteW, finishW, validW, misalignW
  );

  modport slave (
    input  en, validM, pcM, ALUResultM, writeDataM, writeRegM,
           regWriteM, memWriteM, mem2regM, finishM, memSizeM, memUnsignedM,
    output stallM, readDataW, ALUResultW, pcW, writeDataW, writeRegW,
           regWriteW, mem2regW, memWriteW, finishW, validW, misalignW
  );
endinterface

// File: rtl/memory_stage_mc_align.sv
// rtl/memory_stage_mc_align.sv - dmem_align: store lane enables/replication, load extract/extend, misalign flag
module dmem_align
  import mem_pkg::*;
#(
  parameter int WORD_W = MEM_WORD
) (
  input  logic [1:0]          i_addr_lo,
  input  mem_size_t           i_size,
  input  logic                i_unsigned,
  input  logic [WORD_W-1:0]   i_wdata,
  input  logic [WORD_W-1:0]   i_rdata,
  output logic [WORD_W/8-1:0] o_be,
  output logic [WORD_W-1:0]   o_wdata,
  output logic [WORD_W-1:0]   o_rdata,
  output logic                o_misalign
);
  localparam int NB = WORD_W / 8;

  logic [1:0]  w_lo;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lanes are computed from the aligned-down offset; the caller decides whether misalignment traps
  always_comb begin
    o_misalign = 1'b0;
    w_lo       = i_addr_lo;
    w_byte     = '0;
    w_half     = '0;
    o_be       = '1;
    o_wdata    = i_wdata;
    o_rdata    = i_rdata;
    case (i_size)
      MEM_B: begin
        o_be    = NB'(1) << w_lo;
        o_wdata = {NB{i_wdata[7:0]}};
        w_byte  = 8'(i_rdata >> {w_lo, 3'b000});
        o_rdata = i_unsigned ? {{(WORD_W-8){1'b0}}, w_byte}
                             : {{(WORD_W-8){w_byte[7]}}, w_byte};
      end
      MEM_H: begin
        o_misalign = i_addr_lo[0];
        w_lo       = {i_addr_lo[1], 1'b0};
        o_be       = NB'(3) << w_lo;
        o_wdata    = {(NB/2){i_wdata[15:0]}};
        w_half     = 16'(i_rdata >> {w_lo, 3'b000});
        o_rdata    = i_unsigned ? {{(WORD_W-16){1'b0}}, w_half}
                                : {{(WORD_W-16){w_half[15]}}, w_half};
      end
      default: begin
        o_misalign = |i_addr_lo;
        w_lo       = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/memory_stage_mc.sv
// rtl/memory_stage_mc.sv - multi-cycle data-memory stage feeding the M->W register (option: MEM_MISALIGN_TRAP_EN)
module memory_stage_mc
  import mem_pkg::*;
#(
  parameter int WORD_W      = MEM_WORD,
  parameter int DMEM_POWER  = 18,
  parameter int REG_SIZE    = MEM_REG_SIZE,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  memory_stage_mc_if.slave m
);
  localparam int         NB     = WORD_W / 8;
  localparam logic       MULTI  = (MEM_LATENCY > 1);
  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  mem_state_t          r_state;
  logic [2:0]          r_cnt;
  w_ctrl_t             r_ctrl;
  logic [WORD_W-1:0]   r_read_data;
  logic [WORD_W-1:0]   r_alu_result;
  logic [WORD_W-1:0]   r_pc;
  logic [WORD_W-1:0]   r_write_data;
  logic [REG_SIZE-1:0] r_write_reg;
  logic [WORD_W-1:0]   r_mem [0:(1<<DMEM_POWER)-1];

  logic [DMEM_POWER-1:0] w_idx;
  mem_size_t             w_size;
  logic [NB-1:0]         w_be;
  logic [WORD_W-1:0]     w_st_data;
  logic [WORD_W-1:0]     w_rd_word;
  logic [WORD_W-1:0]     w_ld_data;
  logic                  w_misalign;
  logic                  w_trap;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_take;
  w_ctrl_t               w_ctrl_next;
  logic                  w_unused_addr;

  // Upper address bits wrap onto the RAM
  assign w_idx         = m.ALUResultM[DMEM_POWER+1:2];
  assign w_unused_addr = ^m.ALUResultM[WORD_W-1:DMEM_POWER+2];
  assign w_size        = decode_size(m.memSizeM);
  assign w_rd_word     = r_mem[w_idx];

  dmem_align #(.WORD_W(WORD_W)) u_align (
    .i_addr_lo  (m.ALUResultM[1:0]),
    .i_size     (w_size),
    .i_unsigned (m.memUnsignedM),
    .i_wdata    (m.writeDataM),
    .i_rdata    (w_rd_word),
    .o_be       (w_be),
    .o_wdata    (w_st_data),
    .o_rdata    (w_ld_data),
    .o_misalign (w_misalign)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = w_misalign;
`else
  assign w_trap = 1'b0;
`endif

  assign w_is_load  = m.validM & m.mem2regM & ~w_trap;
  assign w_is_store = m.validM & m.memWriteM & ~w_trap;

  // W takes the real payload unless this edge starts a multi-cycle load or is an intermediate WAIT edge
  assign w_take = (r_state == IDLE) ? !(MULTI && w_is_load) : (r_cnt <= 3'd1);

  // Stall covers the accept cycle and every WAIT cycle but the last; a frozen WAIT keeps stalling
  assign m.stallM = reset_n & ((r_state == IDLE) ? (MULTI & w_is_load)
                                                 : ((r_cnt > 3'd1) | ~m.en));

  assign w_ctrl_next = '{
    valid:     m.validM,
    reg_write: m.validM & m.regWriteM & ~w_trap,
    mem2reg:   m.validM & m.mem2regM,
    mem_write: m.validM & m.memWriteM & ~w_trap,
    finish:    m.validM & m.finishM,
    misalign:  m.validM & w_trap
  };

  // Byte-lane RAM write at the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (reset_n && m.en && r_state == IDLE && w_is_store) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
      end
    end
  end

  // FSM, latency counter and M->W register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ctrl       <= '0;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_pc         <= '0;
      r_write_data <= '0;
      r_write_reg  <= '0;
    end else if (m.en) begin
      if (r_state == IDLE) begin
        if (MULTI && w_is_load) begin
          r_state <= WAIT;
          r_cnt   <= LAT_M1;
        end
      end else if (r_cnt <= 3'd1) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt - 3'd1;
      end

      if (w_take && m.validM) begin
        r_ctrl       <= w_ctrl_next;
        r_read_data  <= m.mem2regM ? w_ld_data : '0;
        r_alu_result <= m.ALUResultM;
        r_pc         <= m.pcM;
        r_write_data <= m.writeDataM;
        r_write_reg  <= m.writeRegM;
      end else begin
        r_ctrl       <= '0;
        r_read_data  <= '0;
        r_alu_result <= '0;
        r_pc         <= '0;
        r_write_data <= '0;
        r_write_reg  <= '0;
      end
    end
  end

  assign m.readDataW  = r_read_data;
  assign m.ALUResultW = r_alu_result;
  assign m.pcW        = r_pc;
  assign m.writeDataW = r_write_data;
  assign m.writeRegW  = r_write_reg;
  assign m.regWriteW  = r_ctrl.reg_write;
  assign m.mem2regW   = r_ctrl.mem2reg;
  assign m.memWriteW  = r_ctrl.mem_write;
  assign m.finishW    = r_ctrl.finish;
  assign m.validW     = r_ctrl.valid;
  assign m.misalignW  = r_ctrl.misalign;

endmodule

// File: tb/tb_memory_stage_mc.sv
// tb/tb_memory_stage_mc.sv - directed bench for memory_stage_mc at latency 1 and 3 (honours MEM_MISALIGN_TRAP_EN)
module tb_memory_stage_mc;
  logic clk    = 1'b0;
  logic rst1_n = 1'b0;
  logic rst3_n = 1'b0;
  int   n_chk  = 0;
  int   n_err  = 0;

  always #5 clk = ~clk;

  memory_stage_mc_if #(.WORD_W(32), .REG_SIZE(5)) if1 ();
  memory_stage_mc_if #(.WORD_W(32), .REG_SIZE(5)) if3 ();

  memory_stage_mc #(.WORD_W(32), .DMEM_POWER(8), .REG_SIZE(5), .MEM_LATENCY(1)) u_l1 (
    .clk     (clk),
    .reset_n (rst1_n),
    .m       (if1)
  );

  memory_stage_mc #(.WORD_W(32), .DMEM_POWER(8), .REG_SIZE(5), .MEM_LATENCY(3)) u_l3 (
    .clk     (clk),
    .reset_n (rst3_n),
    .m       (if3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic v, input logic st, input logic ld, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd);
    if1.validM = v; if1.memWriteM = st; if1.mem2regM = ld; if1.regWriteM = ld;
    if1.memSizeM = sz; if1.memUnsignedM = uns; if1.ALUResultM = a; if1.writeDataM = wd;
  endtask

  task automatic drv3(input logic v, input logic st, input logic ld, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd);
    if3.validM = v; if3.memWriteM = st; if3.mem2regM = ld; if3.regWriteM = ld;
    if3.memSizeM = sz; if3.memUnsignedM = uns; if3.ALUResultM = a; if3.writeDataM = wd;
  endtask

  task automatic st1(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    drv1(1'b1, 1'b1, 1'b0, sz, 1'b0, a, wd);
    tick();
  endtask

  task automatic ld1(input string tag, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] exp);
    drv1(1'b1, 1'b0, 1'b1, sz, uns, a, 32'h0);
    #1 chk({tag, "_stall"}, if1.stallM, 32'd0);
    tick();
    chk(tag, if1.readDataW, exp);
  endtask

  initial begin
    drv1(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    drv3(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    if1.en = 1'b1; if1.pcM = '0; if1.writeRegM = '0; if1.finishM = 1'b0;
    if3.en = 1'b1; if3.pcM = '0; if3.writeRegM = '0; if3.finishM = 1'b0;

    #2;
    chk("rst_valid1", if1.validW, 32'd0);
    chk("rst_rdata1", if1.readDataW, 32'd0);
    chk("rst_stall1", if1.stallM, 32'd0);
    chk("rst_valid3", if3.validW, 32'd0);
    chk("rst_pc3", if3.pcW, 32'd0);
    #1 rst1_n = 1'b1; rst3_n = 1'b1;

    // Latency 1: word store then load
    if1.pcM = 32'h40;
    st1(2'b10, 32'h100, 32'hDEADBEEF);
    chk("sw_valid", if1.validW, 32'd1);
    chk("sw_memwrite", if1.memWriteW, 32'd1);
    chk("sw_pc", if1.pcW, 32'h40);
    ld1("lw_100", 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    chk("lw_valid", if1.validW, 32'd1);

    // Sub-word stores and sign/zero extension
    st1(2'b00, 32'h101, 32'h0000007F);
    ld1("lb_101", 2'b00, 1'b0, 32'h101, 32'h0000007F);
    ld1("lw_after_sb", 2'b10, 1'b0, 32'h100, 32'hDEAD7FEF);
    st1(2'b00, 32'h103, 32'h00000080);
    ld1("lb_103", 2'b00, 1'b0, 32'h103, 32'hFFFFFF80);
    ld1("lbu_103", 2'b00, 1'b1, 32'h103, 32'h00000080);
    st1(2'b01, 32'h102, 32'h00008001);
    ld1("lh_102", 2'b01, 1'b0, 32'h102, 32'hFFFF8001);
    ld1("lhu_102", 2'b01, 1'b1, 32'h102, 32'h00008001);
    ld1("lw_after_sh", 2'b11, 1'b0, 32'h100, 32'h80017FEF);

    // Address wrap: 0x504 aliases 0x104 in a 256-word RAM
    st1(2'b10, 32'h504, 32'h12345678);
    ld1("lw_wrap", 2'b10, 1'b0, 32'h104, 32'h12345678);

    // Non-memory op and bubble
    drv1(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h55, 32'h0);
    if1.regWriteM = 1'b1; if1.writeRegM = 5'd7; if1.pcM = 32'h80;
    tick();
    chk("alu_regwrite", if1.regWriteW, 32'd1);
    chk("alu_wreg", if1.writeRegW, 32'd7);
    chk("alu_result", if1.ALUResultW, 32'h55);
    chk("alu_rdata", if1.readDataW, 32'd0);
    drv1(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    if1.regWriteM = 1'b1; if1.finishM = 1'b1;
    tick();
    chk("bubble_valid", if1.validW, 32'd0);
    chk("bubble_regwrite", if1.regWriteW, 32'd0);
    chk("bubble_finish", if1.finishW, 32'd0);
    chk("bubble_pc", if1.pcW, 32'd0);
    if1.finishM = 1'b0; if1.pcM = '0; if1.writeRegM = '0;

    // Misaligned word load and store at 0x102
`ifdef MEM_MISALIGN_TRAP_EN
    drv1(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h102, 32'h0);
    tick();
    chk("mis_lw_flag", if1.misalignW, 32'd1);
    chk("mis_lw_regwrite", if1.regWriteW, 32'd0);
    chk("mis_lw_valid", if1.validW, 32'd1);
    st1(2'b10, 32'h102, 32'hCAFEF00D);
    chk("mis_sw_memwrite", if1.memWriteW, 32'd0);
    ld1("mis_sw_ram", 2'b10, 1'b0, 32'h100, 32'h80017FEF);
`else
    ld1("mis_lw_aligned", 2'b10, 1'b0, 32'h102, 32'h80017FEF);
    chk("mis_lw_flag", if1.misalignW, 32'd0);
    st1(2'b10, 32'h102, 32'hCAFEF00D);
    ld1("mis_sw_ram", 2'b10, 1'b0, 32'h100, 32'hCAFEF00D);
`endif
    drv1(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    // Latency 3: single-cycle store, then a plain 3-cycle load
    drv3(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'hA5A55A5A);
    #1 chk("l3_sw_stall", if3.stallM, 32'd0);
    tick();
    chk("l3_sw_valid", if3.validW, 32'd1);
    drv3(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h200, 32'h0);
    #1 chk("l3_c0_stall", if3.stallM, 32'd1);
    tick();
    chk("l3_c1_bubble", if3.validW, 32'd0);
    chk("l3_c1_stall", if3.stallM, 32'd1);
    tick();
    chk("l3_c2_bubble", if3.validW, 32'd0);
    chk("l3_c2_stall", if3.stallM, 32'd0);
    tick();
    chk("l3_data", if3.readDataW, 32'hA5A55A5A);
    chk("l3_valid", if3.validW, 32'd1);
    drv3(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    #1 chk("l3_idle_stall", if3.stallM, 32'd0);

    // Latency 3 with en low for two edges in WAIT
    drv3(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h200, 32'h0);
    tick();
    if3.en = 1'b0;
    #1 chk("en0_stall_a", if3.stallM, 32'd1);
    tick();
    chk("en0_stall_b", if3.stallM, 32'd1);
    chk("en0_valid_b", if3.validW, 32'd0);
    tick();
    chk("en0_stall_c", if3.stallM, 32'd1);
    if3.en = 1'b1;
    #1 chk("en1_stall_d", if3.stallM, 32'd1);
    tick();
    chk("en1_stall_e", if3.stallM, 32'd0);
    chk("en1_valid_e", if3.validW, 32'd0);
    tick();
    chk("en1_data", if3.readDataW, 32'hA5A55A5A);
    chk("en1_valid", if3.validW, 32'd1);

    // Reset pulse during WAIT aborts the load
    tick();
    chk("pre_rst_stall", if3.stallM, 32'd1);
    rst3_n = 1'b0;
    #1 chk("rst_wait_stall", if3.stallM, 32'd0);
    chk("rst_wait_valid", if3.validW, 32'd0);
    chk("rst_wait_rdata", if3.readDataW, 32'd0);
    drv3(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    tick();
    rst3_n = 1'b1;
    tick();
    chk("post_rst_valid", if3.validW, 32'd0);
    drv3(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h200, 32'h0);
    tick();
    tick();
    tick();
    chk("post_rst_data", if3.readDataW, 32'hA5A55A5A);
    drv3(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    tick();

    // Misaligned load on the multi-cycle instance
    drv3(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h202, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    #1 chk("l3_mis_stall", if3.stallM, 32'd0);
    tick();
    chk("l3_mis_flag", if3.misalignW, 32'd1);
`else
    #1 chk("l3_mis_stall", if3.stallM, 32'd1);
    tick();
    tick();
    tick();
    chk("l3_mis_data", if3.readDataW, 32'hA5A55A5A);
`endif
    drv3(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
